// File: rtl/noise_env_pwm.sv
// noise_env_pwm: gates a synchronised noise bit with an SPI-loaded, decaying 8-bit envelope
// and turns the gated level into a registered PWM bitstream for an RC-filter DAC.
module noise_env_pwm #(
    parameter int ENV_W      = 8,
    parameter int DIV_W      = 16,
    parameter int FRAME_BITS = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             noise_in,
    input  logic             spi_clock,
    input  logic             spi_data,
    input  logic             spi_cs,
    output logic             pwm_out,
    output logic [ENV_W-1:0] level,
    output logic             cfg_loaded,
    output logic             frame_err
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(FRAME_BITS + 1);

    logic [2:0]            sck_q, cs_q;
    logic [1:0]            mosi_q, noise_q;
    logic                  sck_rise, cs_fall, cs_rise, cs_low, noise_s;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d, bit_base;
    logic                  armed_q, armed_d;
    logic [ENV_W-1:0]      env_q, env_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [DIV_W-1:0]      presc_q, presc_d;
    logic [ENV_W-1:0]      level_q, level_d;
    logic [ENV_W-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [ENV_W-1:0]      duty_q, duty_d;
    logic                  pwm_q, pwm_d;
    logic                  cfg_q, cfg_d;
    logic                  err_q, err_d;
    logic                  commit, decay_tick;

    // Synchronisers carry no reset so the pin history survives sys_rst; a reset
    // therefore never fabricates a CS edge, and an interrupted frame stays unarmed.
    always_ff @(posedge sys_clk) begin
        sck_q   <= {sck_q[1:0], spi_clock};
        cs_q    <= {cs_q[1:0], spi_cs};
        mosi_q  <= {mosi_q[0], spi_data};
        noise_q <= {noise_q[0], noise_in};
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign cs_fall  = cs_q[2] & ~cs_q[1];
    assign cs_rise  = ~cs_q[2] & cs_q[1];
    assign cs_low   = ~cs_q[1];
    assign noise_s  = noise_q[1];

    always_comb begin
        bit_base   = cs_fall ? '0 : bitcnt_q;
        shift_d    = (cs_low && sck_rise) ? {shift_q[FRAME_BITS-2:0], mosi_q[1]} : shift_q;
        bitcnt_d   = (cs_low && sck_rise && bit_base != SAT) ? bit_base + CNT_W'(1) : bit_base;
        armed_d    = cs_fall ? 1'b1 : (cs_rise ? 1'b0 : armed_q);
        // Only a frame opened by a CS fall seen since reset may commit.
        commit     = cs_rise && armed_q && bitcnt_q == FULL;
        cfg_d      = commit;
        err_d      = cs_rise && !commit;
        decay_tick = div_q != '0 && presc_q == div_q;
        env_d      = commit ? shift_q[FRAME_BITS-1 -: ENV_W]
                   : (decay_tick && env_q != '0) ? env_q - ENV_W'(1) : env_q;
        div_d      = commit ? shift_q[DIV_W-1:0] : div_q;
        presc_d    = (commit || decay_tick || div_q == '0) ? '0 : presc_q + DIV_W'(1);
        level_d    = noise_s ? env_q : '0;
        pwm_cnt_d  = pwm_cnt_q + ENV_W'(1);
        duty_d     = &pwm_cnt_q ? level_q : duty_q;
        pwm_d      = pwm_cnt_q < duty_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            armed_q   <= 1'b0;
            env_q     <= '0;
            div_q     <= '0;
            presc_q   <= '0;
            level_q   <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            cfg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            armed_q   <= armed_d;
            env_q     <= env_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign level      = level_q;
    assign cfg_loaded = cfg_q;
    assign frame_err  = err_q;
endmodule
